// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-and-add-3), feeding
// the seven-segment display stage; digit code 4'hF renders as blank there.
module bin2bcd_seq #(
    parameter int BIN_W   = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    input  logic             blank_lz,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       d3,
    output logic [3:0]       d2,
    output logic [3:0]       d1,
    output logic [3:0]       d0
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [BIN_W-1:0] MAX_V    = BIN_W'(MAX_VAL);
    localparam logic [3:0]       LAST_CNT = 4'(BIN_W - 1);

    state_t             state_q;
    logic [3:0]         cnt_q;
    logic [BIN_W-1:0]   bin_q;
    logic [15:0]        bcd_q;
    logic               blank_q;
    logic               ovf_pend_q;
    logic               busy_q;
    logic               done_q;
    logic               overflow_q;
    logic [15:0]        digits_q;

    logic [15:0]        bcd_adj_d;
    logic [15+BIN_W:0]  shift_d;
    logic [15:0]        digits_d;

    function automatic logic [3:0] add3(input logic [3:0] n);
        if (n >= 4'd5) begin
            return n + 4'd3;
        end else begin
            return n;
        end
    endfunction

    // Leading zeros become blank codes, scanning down from the thousands digit;
    // the units digit always stays visible.
    function automatic logic [15:0] blank_leading(input logic [15:0] v, input logic en);
        logic [15:0] r;
        r = v;
        if (en && (r[15:12] == 4'd0)) begin
            r[15:12] = 4'hF;
            if (r[11:8] == 4'd0) begin
                r[11:8] = 4'hF;
                if (r[7:4] == 4'd0) begin
                    r[7:4] = 4'hF;
                end else begin
                    r[7:4] = v[7:4];
                end
            end else begin
                r[11:8] = v[11:8];
            end
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Next scratch/shift value for one iteration and the final digit image
    always_comb begin
        bcd_adj_d = {add3(bcd_q[15:12]), add3(bcd_q[11:8]),
                     add3(bcd_q[7:4]),   add3(bcd_q[3:0])};
        shift_d   = {bcd_adj_d, bin_q} << 1;
        if (ovf_pend_q) begin
            digits_d = 16'hFFFF;
        end else begin
            digits_d = blank_leading(bcd_q, blank_q);
        end
    end

    // Conversion FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            bin_q      <= '0;
            bcd_q      <= 16'd0;
            blank_q    <= 1'b0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            digits_q   <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        bin_q      <= bin;
                        bcd_q      <= 16'd0;
                        blank_q    <= blank_lz;
                        ovf_pend_q <= (bin > MAX_V);
                        cnt_q      <= 4'd0;
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
                    end else begin
                        busy_q     <= 1'b0;
                    end
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= shift_d;
                    cnt_q          <= cnt_q + 4'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= FINISH;
                    end else begin
                        state_q <= SHIFT;
                    end
                end
                FINISH: begin
                    // busy stays high one more cycle so it falls together with done
                    digits_q   <= digits_d;
                    overflow_q <= ovf_pend_q;
                    done_q     <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign d3       = digits_q[15:12];
    assign d2       = digits_q[11:8];
    assign d1       = digits_q[7:4];
    assign d0       = digits_q[3:0];

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter that sits directly upstream of the four-digit seven-segment display multiplexer. It accepts a 14-bit binary value on a start strobe, converts it with an iterative shift-and-add-3 (double-dabble) algorithm, and drives the four BCD digit outputs `d3..d0` that the display stage decodes. It also supports optional leading-zero blanking and overflow indication. Digit value 4'hF is the blank code, because the display stage renders any digit above 9 as all segments off.

## Interface
- `BIN_W`, default 14: width of the binary input. Fixed at 14 for four digits; other values are unsupported.
- `MAX_VAL`, default 9999: largest convertible value. Inputs above it flag overflow.
- `clk`  input  1  system clock; every register updates on the rising edge.
- `rst`  input  1  reset; asynchronous, active-high.
- `start`  input  1  conversion request, sampled only in IDLE.
- `bin`  input  14  binary value, sampled with `start`.
- `blank_lz`  input  1  leading-zero blanking enable, sampled with `start`.
- `busy`  output  1  high whenever the state is not IDLE.
- `done`  output  1  one-cycle pulse when new digits are valid.
- `overflow`  output  1  result flag; high means the last accepted `bin` exceeded `MAX_VAL`.
- `d3`, `d2`, `d1`, `d0`  output  4 each  BCD digits (thousands to units), registered.

## Operation
- FSM states are IDLE, SHIFT and FINISH.
- IDLE with `start`=1:
  - latch `bin` into the shift register;
  - clear the 16-bit BCD scratch;
  - latch `blank_lz`;
  - compute the overflow flag as (`bin` > `MAX_VAL`);
  - set the iteration counter to 0 and go to SHIFT.
- SHIFT, once per cycle:
  - each BCD nibble ≥ 5 gets +3;
  - then the {BCD scratch, binary register} concatenation shifts left by 1;
  - the counter increments;
  - after the iteration with counter = BIN_W−1 (14 iterations total), go to FINISH.
- FINISH, always followed by IDLE:
  - if overflow: `d3..d0` = 4'hF each and `overflow`=1;
  - else: load `d3..d0` from the scratch and set `overflow`=0;
  - if `blank_lz`=1, replace each leading zero digit with 4'hF, scanning from `d3` downward and stopping at the first nonzero digit;
  - `d0` is never blanked, so a value of 0 shows as F,F,F,0.
- In FINISH, `done` is registered high for exactly one cycle.
- `d3..d0` and `overflow` hold their values until the next FINISH. They never show intermediate scratch values.
- `start` while `busy`=1 is ignored; nothing is queued.
- `bin` and `blank_lz` may change freely after they are accepted.
- The counter is 4 bits wide. The BCD scratch is 16 bits; +3 is applied per nibble and nibble carries are never needed.

## Timing
- Reset values: `d3..d0`=4'h0, `overflow`=0, `done`=0, `busy`=0, state IDLE, counter 0.
- Asserting `rst` mid-conversion aborts the conversion immediately and asynchronously, returning every output to its reset value. Conversion resumes only with a new `start` after `rst` is deasserted.
- Cycle-level sequence for `start` accepted at rising edge k:
  - `busy` is high from edge k;
  - SHIFT iterations occur at edges k+1 through k+14;
  - the FINISH update occurs at edge k+15.
  - `d3..d0`, `overflow` and `done` are all valid after edge k+15.
  - At edge k+16, `busy` and `done` fall together.
- Latency from `start` to `done` is 15 cycles. Each conversion occupies 16 cycles, so throughput is one conversion per 16 cycles.
- A `start` held high during the cycle in which `done` is high is accepted, because the state is IDLE at that edge. This gives back-to-back conversions with no idle gap.
- `start` held continuously high converts repeatedly, re-sampling `bin` each time the FSM is in IDLE.
- Overflow conversions take the same 15-cycle latency as normal ones.

## Test plan
- Basic conversion: reset, then `bin`=1234, `blank_lz`=0, one-cycle `start`.
  - Required: `done` exactly 15 cycles later; `d3..d0`=1,2,3,4; `overflow`=0.
- Boundary values with `blank_lz`=0:
  - `bin`=9999 → 9,9,9,9;
  - `bin`=0 → 0,0,0,0;
  - `bin`=10000 → F,F,F,F with `overflow`=1.
  - `bin`=16383 → F,F,F,F with `overflow`=1.
- Blanking with `blank_lz`=1:
  - `bin`=42 → F,F,4,2;
  - `bin`=0 → F,F,F,0;
  - `bin`=1005 → 1,0,0,5 (interior zeros kept).
- Start during busy: `start` with `bin`=77, then another `start` at cycle 5 with `bin`=8888.
  - Required: only one `done`, with digits 0,0,7,7.
  - A following conversion clears `overflow`.
- Back-to-back and reset:
  - `start` held high across `done` → second conversion's `done` arrives 16 cycles after the first.
  - `rst` pulsed at cycle 8 of a conversion → `busy`=0 and digits 0,0,0,0 immediately; no `done` until a new `start`.
